// File: rtl/str_edge_byte_packer.sv
// Byte-to-word packer: gathers a little-endian stream of bytes into
// BYTES_PER_WORD-byte words behind a valid/ready output holding register.
// A flush emits a partial word with a per-byte keep mask. While a flush is
// pending, no more bytes are accepted, so flushed-word boundaries are exact.
module str_edge_byte_packer #(
  parameter int BYTES_PER_WORD = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    data_in,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          flush,
  output logic [8*BYTES_PER_WORD-1:0]   data_out,
  output logic [BYTES_PER_WORD-1:0]     out_keep,
  output logic                          out_valid,
  input  logic                          out_ready
);

  localparam int CW = $clog2(BYTES_PER_WORD + 1);
  localparam logic [CW-1:0] FULL = CW'(BYTES_PER_WORD);

  // Accumulator state
  logic [CW-1:0]                 acc_cnt_reg, acc_cnt_next;
  logic [8*BYTES_PER_WORD-1:0]   acc_reg, acc_next;
  logic                          flush_pend_reg, flush_pend_next;

  // Output holding register
  logic [8*BYTES_PER_WORD-1:0]   data_out_reg, data_out_next;
  logic [BYTES_PER_WORD-1:0]     keep_reg, keep_next;
  logic                          valid_reg, valid_next;

  // Per-cycle working values
  logic                          accept;
  logic                          slot_free;
  logic [CW-1:0]                 cnt_w;
  logic [8*BYTES_PER_WORD-1:0]   acc_w;
  logic [8*BYTES_PER_WORD-1:0]   load_data;
  logic [BYTES_PER_WORD-1:0]     keep_w;
  logic                          flush_req;
  logic                          emit;

  // in_ready depends on registered state only, so there is no path from
  // in_valid or out_ready to in_ready.
  assign in_ready  = (acc_cnt_reg < FULL) && !flush_pend_reg;
  assign accept    = in_valid && in_ready;
  assign slot_free = !valid_reg || out_ready;
  assign cnt_w     = acc_cnt_reg + CW'(accept);
  // A flush with nothing buffered and no byte arriving is dropped here.
  assign flush_req = flush_pend_reg || (flush && (cnt_w != '0));
  assign emit      = slot_free && ((cnt_w == FULL) || flush_req);

  // Insert the accepted byte at its lane and build the keep mask and the
  // zero-padded load word.
  generate
    for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
      assign acc_w[8*gi +: 8] = (accept && (acc_cnt_reg == CW'(gi)))
                                ? data_in : acc_reg[8*gi +: 8];
      assign keep_w[gi] = (CW'(gi) < cnt_w);
      assign load_data[8*gi +: 8] = keep_w[gi] ? acc_w[8*gi +: 8] : 8'h00;
    end
  endgenerate

  // Next-state logic: either move the accumulator into the output register
  // or keep accumulating, and retire the held word when it is taken.
  always_comb begin
    acc_cnt_next    = cnt_w;
    acc_next        = acc_w;
    flush_pend_next = flush_req;
    data_out_next   = data_out_reg;
    keep_next       = keep_reg;
    valid_next      = valid_reg;
    if (valid_reg && out_ready) begin
      valid_next = 1'b0;
    end
    if (emit) begin
      data_out_next   = load_data;
      keep_next       = keep_w;
      valid_next      = 1'b1;
      acc_cnt_next    = '0;
      acc_next        = '0;
      flush_pend_next = 1'b0;
    end
  end

  // State registers; reset discards any partial or held word.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_cnt_reg    <= '0;
      acc_reg        <= '0;
      flush_pend_reg <= 1'b0;
      data_out_reg   <= '0;
      keep_reg       <= '0;
      valid_reg      <= 1'b0;
    end else begin
      acc_cnt_reg    <= acc_cnt_next;
      acc_reg        <= acc_next;
      flush_pend_reg <= flush_pend_next;
      data_out_reg   <= data_out_next;
      keep_reg       <= keep_next;
      valid_reg      <= valid_next;
    end
  end

  assign data_out  = data_out_reg;
  assign out_keep  = keep_reg;
  assign out_valid = valid_reg;

endmodule

// File: tb/tb_str_edge_byte_packer.sv
// Directed testbench for str_edge_byte_packer (BYTES_PER_WORD = 4).
module tb_str_edge_byte_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data_in;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [31:0] data_out;
  logic [3:0]  out_keep;
  logic        out_valid;
  logic        out_ready;

  int checks = 0;
  int errors = 0;

  str_edge_byte_packer #(.BYTES_PER_WORD(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .data_out  (data_out),
    .out_keep  (out_keep),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; data_in = 8'h00; flush = 1'b0; out_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++;
    if (out_keep !== 4'h0) begin errors++; $display("FAIL reset_keep: got %h expected 0", out_keep); end
    checks++;
    if (data_out !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", data_out); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    $display("test_reset done");
  endtask

  task automatic test_single_word();
    logic [7:0] bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_in = bytes[i]; in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || data_out !== 32'h44332211 || out_keep !== 4'hF) begin
      errors++; $display("FAIL single_word: got v=%b d=%h k=%h expected v=1 d=44332211 k=f", out_valid, data_out, out_keep);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL single_word_drop: got %b expected 0", out_valid); end
    $display("test_single_word done");
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      data_in = 8'(i); in_valid = 1'b1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready byte %0d: got %b expected 1", i, in_ready); end
      step();
      if (i == 4) begin
        checks++;
        if (out_valid !== 1'b1 || data_out !== 32'h04030201 || out_keep !== 4'hF) begin
          errors++; $display("FAIL stream_word0: got v=%b d=%h k=%h expected v=1 d=04030201 k=f", out_valid, data_out, out_keep);
        end
      end else if (i == 5) begin
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_gap: got %b expected 0", out_valid); end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || data_out !== 32'h08070605 || out_keep !== 4'hF) begin
      errors++; $display("FAIL stream_word1: got v=%b d=%h k=%h expected v=1 d=08070605 k=f", out_valid, data_out, out_keep);
    end
    step();
    $display("test_stream done");
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      data_in = 8'hA0 + 8'(i); in_valid = 1'b1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready byte %0d: got %b expected 1", i, in_ready); end
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full: got in_ready=%b expected 0", in_ready); end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || data_out !== 32'hA3A2A1A0 || out_keep !== 4'hF || in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold: got v=%b d=%h k=%h r=%b expected v=1 d=a3a2a1a0 k=f r=0", out_valid, data_out, out_keep, in_ready);
      end
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || data_out !== 32'hA7A6A5A4 || out_keep !== 4'hF) begin
      errors++; $display("FAIL bp_second: got v=%b d=%h k=%h expected v=1 d=a7a6a5a4 k=f", out_valid, data_out, out_keep);
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got in_ready=%b expected 1", in_ready); end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b expected 0", out_valid); end
    $display("test_backpressure done");
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    data_in = 8'hAA; in_valid = 1'b1; step();
    data_in = 8'hBB; step();
    in_valid = 1'b0; flush = 1'b1; step();
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || data_out !== 32'h0000BBAA || out_keep !== 4'h3) begin
      errors++; $display("FAIL flush_partial: got v=%b d=%h k=%h expected v=1 d=0000bbaa k=3", out_valid, data_out, out_keep);
    end
    step();
    flush = 1'b1; step();
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_empty: got %b expected 0", out_valid); end
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_empty_late: got %b expected 0", out_valid); end
    $display("test_flush done");
  endtask

  task automatic test_flush_same_cycle();
    out_ready = 1'b1;
    data_in = 8'hAA; in_valid = 1'b1; step();
    data_in = 8'hCC; flush = 1'b1; step();
    in_valid = 1'b0; flush = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || data_out !== 32'h0000CCAA || out_keep !== 4'h3) begin
      errors++; $display("FAIL flush_same_cycle: got v=%b d=%h k=%h expected v=1 d=0000ccaa k=3", out_valid, data_out, out_keep);
    end
    step();
    $display("test_flush_same_cycle done");
  endtask

  task automatic test_flush_blocked();
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      data_in = 8'(i); in_valid = 1'b1; step();
    end
    data_in = 8'h55; flush = 1'b1; step();
    flush = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || data_out !== 32'h04030201) begin
      errors++; $display("FAIL flush_pending: got r=%b v=%b d=%h expected r=0 v=1 d=04030201", in_ready, out_valid, data_out);
    end
    data_in = 8'h66; step();
    in_valid = 1'b0; out_ready = 1'b1; step();
    checks++;
    if (out_valid !== 1'b1 || data_out !== 32'h00000055 || out_keep !== 4'h1) begin
      errors++; $display("FAIL flush_blocked_word: got v=%b d=%h k=%h expected v=1 d=00000055 k=1", out_valid, data_out, out_keep);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_blocked_end: got v=%b r=%b expected v=0 r=1", out_valid, in_ready);
    end
    $display("test_flush_blocked done");
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      data_in = 8'h10 + 8'(i); in_valid = 1'b1; step();
    end
    in_valid = 1'b0; rst = 1'b1; step();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_keep !== 4'h0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_mid: got v=%b k=%h r=%b expected v=0 k=0 r=1", out_valid, out_keep, in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_in = 8'h30 + 8'(i); in_valid = 1'b1; step();
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || data_out !== 32'h33323130 || out_keep !== 4'hF) begin
      errors++; $display("FAIL reset_fresh_word: got v=%b d=%h k=%h expected v=1 d=33323130 k=f", out_valid, data_out, out_keep);
    end
    step();
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_stream();
    test_backpressure();
    test_flush();
    test_flush_same_cycle();
    test_flush_blocked();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
